// File: rtl/arith_pkg.sv
// Shared constants and types for the arithmetic-unit sweep sequencer.
package arith_pkg;
  localparam int RES_W = 4;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/arith_ref_model.sv
// Combinational golden model of the 2-bit ALU; results zero-extended to RES_W.
module arith_ref_model
  import arith_pkg::*;
(
  input  logic [1:0]       a,
  input  logic [1:0]       b,
  input  logic             ci,
  input  logic [1:0]       s,
  output logic [RES_W-1:0] expected
);
  always_comb begin
    expected = '0;
    case (s)
      OP_PASS: expected = {2'b00, a};
      OP_NAND: expected = {2'b00, ~(a & b)};
      OP_ADD:  expected = {2'b00, a} + {2'b00, b} + {3'b000, ci};
      OP_MUL:  expected = {2'b00, a} * {2'b00, b};
      default: expected = '0;
    endcase
  end
endmodule

// File: rtl/arith_sweep_ctrl.sv
// Sweeps the ALU through all four ops on one latched operand set, captures
// each result and flags any that disagree with the reference model.
module arith_sweep_ctrl
  import arith_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           a_in,
  input  logic [1:0]           b_in,
  input  logic                 ci_in,
  output logic [1:0]           alu_a,
  output logic [1:0]           alu_b,
  output logic                 alu_ci,
  output logic [1:0]           alu_s,
  input  logic [RES_W-1:0]     alu_out,
  output logic [4*RES_W-1:0]   res,
  output logic [3:0]           err_mask,
  output logic                 busy,
  output logic                 done
);
  localparam logic [2:0] SETTLE_C = 3'(SETTLE);

  state_t           state, state_nx;
  logic [1:0]       op;
  logic [2:0]       cnt;
  logic             cap;
  logic [RES_W-1:0] expected;

  arith_ref_model u_ref (
    .a        (alu_a),
    .b        (alu_b),
    .ci       (alu_ci),
    .s        (op),
    .expected (expected)
  );

  assign cap = (state == RUN) && (cnt == SETTLE_C);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cap && op == OP_MUL) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == RUN);
    done  = (state == DONE);
    alu_s = busy ? op : OP_PASS;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ci   <= 1'b0;
      res      <= '0;
      err_mask <= '0;
      op       <= '0;
      cnt      <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        alu_a    <= a_in;
        alu_b    <= b_in;
        alu_ci   <= ci_in;
        res      <= '0;
        err_mask <= '0;
        op       <= '0;
        cnt      <= '0;
      end else if (state == RUN) begin
        if (cap) begin
          res[{op, 2'b00} +: RES_W] <= alu_out;
          // sticky within a sweep: only the next accepted start clears it
          if (alu_out != expected) err_mask[op] <= 1'b1;
          cnt <= '0;
          if (op != OP_MUL) op <= op + 2'd1;
        end else begin
          cnt <= cnt + 3'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_arith_sweep_ctrl.sv
// Self-checking bench: behavioural ALU in the loop, scoreboard of expected sweeps.
module tb_arith_sweep_ctrl;
  logic        clk = 1'b0;
  logic        rst, start, start0;
  logic [1:0]  a_in, b_in;
  logic        ci_in;
  logic        fz;
  logic [1:0]  alu_a, alu_b, alu_s, alu_a0, alu_b0, alu_s0;
  logic        alu_ci, alu_ci0;
  logic [3:0]  alu_out, alu_out0, err_mask, err_mask0;
  logic [15:0] res, res0;
  logic        busy, done, busy0, done0;

  int ncmp = 0;
  int nerr = 0;
  int cyc = 0;
  int busy_run = 0;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  err;
    int          cyc;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [1:0]  a, b;
    logic        ci, fz;
    logic [15:0] res;
    logic [3:0]  err;
  } vec_t;
  vec_t vt[4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] alu_fn(logic [1:0] a, logic [1:0] b, logic ci, logic [1:0] s);
    case (s)
      2'd0:    return {2'b00, a};
      2'd1:    return {2'b00, ~(a & b)};
      2'd2:    return 4'(a) + 4'(b) + 4'(ci);
      default: return 4'(a) * 4'(b);
    endcase
  endfunction

  function automatic logic [15:0] sweep_res(logic [1:0] a, logic [1:0] b, logic ci);
    return {alu_fn(a, b, ci, 2'd3), alu_fn(a, b, ci, 2'd2), alu_fn(a, b, ci, 2'd1), alu_fn(a, b, ci, 2'd0)};
  endfunction

  // ALU stand-in; fz models a broken multiplier that always returns 0
  assign alu_out  = (fz && alu_s == 2'd3) ? 4'd0 : alu_fn(alu_a, alu_b, alu_ci, alu_s);
  assign alu_out0 = alu_fn(alu_a0, alu_b0, alu_ci0, alu_s0);

  arith_sweep_ctrl #(.SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .ci_in(ci_in),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci), .alu_s(alu_s), .alu_out(alu_out),
    .res(res), .err_mask(err_mask), .busy(busy), .done(done)
  );

  arith_sweep_ctrl #(.SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .a_in(a_in), .b_in(b_in), .ci_in(ci_in),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_ci(alu_ci0), .alu_s(alu_s0), .alu_out(alu_out0),
    .res(res0), .err_mask(err_mask0), .busy(busy0), .done(done0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // scoreboard: every done pulse must match the oldest pending sweep
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_run++;
    else if (!done) busy_run = 0;
    if (done) begin
      if (q.size() == 0) begin
        ncmp++;
        nerr++;
        $display("FAIL spurious_done: done=1 with no sweep pending (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("sb_res", 32'(res), 32'(e.res));
        chk("sb_err_mask", 32'(err_mask), 32'(e.err));
        chk("sb_done_cycle", 32'(cyc), 32'(e.cyc));
        chk("sb_busy_len", 32'(busy_run), 32'd8);
      end
      busy_run = 0;
    end
  end

  task automatic go(input logic [1:0] a, input logic [1:0] b, input logic ci,
                    input logic [15:0] r, input logic [3:0] e);
    @(negedge clk);
    a_in = a; b_in = b; ci_in = ci; start = 1'b1;
    q.push_back('{r, e, cyc + 1 + 8});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; start0 = 1'b0; fz = 1'b0;
    a_in = '0; b_in = '0; ci_in = 1'b0;
    vt[0] = '{2'd3, 2'd2, 1'b1, 1'b0, 16'h6613, 4'h0};
    vt[1] = '{2'd3, 2'd3, 1'b1, 1'b1, 16'h0703, 4'h8};
    vt[2] = '{2'd2, 2'd1, 1'b0, 1'b0, 16'h2332, 4'h0};
    vt[3] = '{2'd0, 2'd3, 1'b1, 1'b1, 16'h0430, 4'h0};

    repeat (3) @(negedge clk);
    chk("rst_res", 32'(res), 0);
    chk("rst_err_mask", 32'(err_mask), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_alu_s", 32'(alu_s), 0);
    chk("rst_alu_ops", 32'({alu_a, alu_b, alu_ci}), 0);
    rst = 1'b0;

    foreach (vt[i]) begin
      fz = vt[i].fz;
      go(vt[i].a, vt[i].b, vt[i].ci, vt[i].res, vt[i].err);
      wait_done("vec");
      @(negedge clk);
    end
    fz = 1'b0;

    // start during DONE is ignored, results hold
    go(2'd2, 2'd2, 1'b0, 16'h4412, 4'h0);
    wait_done("done_start");
    start = 1'b1; a_in = 2'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      chk("done_start_busy", 32'(busy), 0);
      chk("done_start_res_hold", 32'(res), 32'h4412);
      @(negedge clk);
    end

    // start held high: accepts every 10 cycles with operands at each accept edge
    n = cyc;
    a_in = 2'd1; b_in = 2'd2; ci_in = 1'b0; start = 1'b1;
    q.push_back('{sweep_res(2'd1, 2'd2, 1'b0), 4'h0, n + 9});
    q.push_back('{sweep_res(2'd2, 2'd1, 1'b1), 4'h0, n + 19});
    q.push_back('{sweep_res(2'd3, 2'd3, 1'b0), 4'h0, n + 29});
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 4)  begin a_in = 2'd2; b_in = 2'd1; ci_in = 1'b1; end
      if (k == 14) begin a_in = 2'd3; b_in = 2'd3; ci_in = 1'b0; end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_all_sweeps_done", 32'(q.size()), 0);

    // rst mid-sweep while alu_s == ADD aborts without a done pulse
    go(2'd3, 2'd2, 1'b1, 16'h6613, 4'h0);
    n = 0;
    while (alu_s != 2'd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_add", 32'(alu_s), 2);
    rst = 1'b1;
    void'(q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    chk("abort_res", 32'(res), 0);
    chk("abort_err_mask", 32'(err_mask), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_alu_s", 32'(alu_s), 0);
    chk("abort_done", 32'(done), 0);
    repeat (12) @(negedge clk);
    go(2'd1, 2'd1, 1'b0, 16'h1221, 4'h0);
    wait_done("post_abort");
    @(negedge clk);

    // SETTLE=0 instance: one cycle per op
    a_in = 2'd0; b_in = 2'd0; ci_in = 1'b0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("s0_alu_s", 32'(alu_s0), 32'(k));
      chk("s0_busy", 32'(busy0), 1);
      @(negedge clk);
    end
    chk("s0_done", 32'(done0), 1);
    chk("s0_res", 32'(res0), 32'h0030);
    chk("s0_err_mask", 32'(err_mask0), 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
